// File: rtl/spi_seq_pkg.sv
// Shared types and constants for the SPI peripheral sequencer.
package spi_seq_pkg;

  localparam int SEL_W = 16;
  localparam logic [7:0] DUMMY_BYTE = 8'h00;
  localparam logic [7:0] TMO_BYTE = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WR_IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT
  } seqState_t;

  function automatic logic [SEL_W-1:0] onehotSel(input logic [3:0] periph);
    onehotSel = SEL_W'(1) << periph;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer followed by an edge register; rise/fall are one-cycle pulses.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic iCLK,
  input  logic iRST,
  input  logic iASYNC,
  output logic oRISE,
  output logic oFALL
);

  // [0],[1] synchronize; [2] holds the previous synchronized level.
  logic [2:0] pipe;

  always_ff @(posedge iCLK) begin
    if (iRST) pipe <= {3{RST_VAL}};
    else      pipe <= {pipe[1:0], iASYNC};
  end

  assign oRISE = pipe[1] & ~pipe[2];
  assign oFALL = ~pipe[1] & pipe[2];

endmodule

// File: rtl/spi_periph_sequencer.sv
// System-clock side of the SPI slave: command decode, req/ack bus sequencing, read prefetch.
// Optional ack timeout is enabled with `define SPI_SEQ_TIMEOUT_EN.
module spi_periph_sequencer
  import spi_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TMO_CYC = 255
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSPI_SS_n,
  input  logic              iSPI_WRITE_SIG,
  input  logic              iSPI_READ_SIG,
  input  logic [7:0]        iSPI_RCV_CMD,
  input  logic [7:0]        iSPI_RCV_BYTE,
  output logic [7:0]        oSPI_SEND_BYTE,
  output logic [SEL_W-1:0]  oBUS_SEL,
  output logic [ADDR_W-1:0] oBUS_ADDR,
  output logic [7:0]        oBUS_WDATA,
  output logic              oBUS_WR,
  output logic              oBUS_RD,
  input  logic              iBUS_ACK,
  input  logic [7:0]        iBUS_RDATA,
  output logic              oBUSY,
  output logic              oERR_OVR,
  output logic              oERR_TMO
);

  logic ssRise, ssFall, wrRise, wrFall, rdRise, rdFall;
  logic unused;

  spi_sync_edge #(.RST_VAL(1'b1)) uSyncSs (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(iSPI_SS_n), .oRISE(ssRise), .oFALL(ssFall));
  spi_sync_edge #(.RST_VAL(1'b0)) uSyncWr (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(iSPI_WRITE_SIG), .oRISE(wrRise), .oFALL(wrFall));
  spi_sync_edge #(.RST_VAL(1'b0)) uSyncRd (
    .iCLK(iCLK), .iRST(iRST), .iASYNC(iSPI_READ_SIG), .oRISE(rdRise), .oFALL(rdFall));

  assign unused = wrFall ^ rdFall;

  seqState_t state, stateNxt;
  logic [SEL_W-1:0]  sel, selNxt;
  logic [ADDR_W-1:0] addr, addrNxt;
  logic [7:0]        wdata, wdataNxt, sendByte, sendNxt, pfBuf, pfNxt;
  logic              errOvr, ovrNxt, closePend, closeNxt, cmdSeen, cmdSeenNxt;
  logic              goIdle, reqActive, tmoHit, done;

  // Bus handshake: WR/RD is a request held high until ack is sampled high on a
  // rising edge; it drops the following cycle and is never withdrawn early.
  assign reqActive = (state == WR_REQ) || (state == RD_REQ);
  assign done      = iBUS_ACK | tmoHit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmoCnt;
  logic          tmoErr;

  assign tmoHit = reqActive && !iBUS_ACK && (tmoCnt == TW'(TMO_CYC - 1));

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      tmoCnt <= '0;
      tmoErr <= 1'b0;
    end else begin
      if (reqActive && !iBUS_ACK && !tmoHit) tmoCnt <= tmoCnt + TW'(1);
      else                                   tmoCnt <= '0;
      if (tmoHit) tmoErr <= 1'b1;
    end
  end

  assign oERR_TMO = tmoErr;
`else
  assign tmoHit   = 1'b0;
  assign oERR_TMO = 1'b0;
`endif

  always_comb begin
    stateNxt   = state;
    selNxt     = sel;
    addrNxt    = addr;
    wdataNxt   = wdata;
    sendNxt    = sendByte;
    pfNxt      = pfBuf;
    ovrNxt     = errOvr;
    closeNxt   = closePend;
    cmdSeenNxt = cmdSeen;
    goIdle     = 1'b0;
    case (state)
      IDLE: begin
        closeNxt   = 1'b0;
        cmdSeenNxt = 1'b0;
        if (ssFall) stateNxt = CMD;
      end
      CMD: begin
        // First read strobe starts the command byte; the second ends it.
        if (ssRise) goIdle = 1'b1;
        else if (rdRise) begin
          if (cmdSeen) begin
            selNxt   = onehotSel(iSPI_RCV_CMD[6:3]);
            addrNxt  = ADDR_W'(iSPI_RCV_CMD[2:0]);
            sendNxt  = DUMMY_BYTE;
            stateNxt = iSPI_RCV_CMD[7] ? WR_IDLE : RD_REQ;
          end else begin
            cmdSeenNxt = 1'b1;
          end
        end
      end
      WR_IDLE: begin
        if (ssRise) goIdle = 1'b1;
        else if (wrRise) begin
          wdataNxt = iSPI_RCV_BYTE;
          stateNxt = WR_REQ;
        end
      end
      WR_REQ: begin
        if (wrRise) ovrNxt = 1'b1;
        if (ssRise) closeNxt = 1'b1;
        if (done) begin
          addrNxt = addr + ADDR_W'(1);
          if (closePend || ssRise) goIdle = 1'b1;
          else                     stateNxt = WR_IDLE;
        end
      end
      RD_REQ: begin
        // Byte started before the fetch landed: shift out the dummy instead.
        if (rdRise) begin
          sendNxt = DUMMY_BYTE;
          ovrNxt  = 1'b1;
        end
        if (ssRise) closeNxt = 1'b1;
        if (done) begin
          pfNxt   = iBUS_ACK ? iBUS_RDATA : TMO_BYTE;
          addrNxt = addr + ADDR_W'(1);
          if (closePend || ssRise) goIdle = 1'b1;
          else                     stateNxt = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (ssRise) goIdle = 1'b1;
        else if (rdRise) begin
          sendNxt  = pfBuf;
          stateNxt = RD_REQ;
        end
      end
      default: goIdle = 1'b1;
    endcase
    if (goIdle) begin
      stateNxt = IDLE;
      selNxt   = '0;
      addrNxt  = '0;
      wdataNxt = '0;
      sendNxt  = DUMMY_BYTE;
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      sel       <= '0;
      addr      <= '0;
      wdata     <= '0;
      sendByte  <= '0;
      pfBuf     <= '0;
      errOvr    <= 1'b0;
      closePend <= 1'b0;
      cmdSeen   <= 1'b0;
    end else begin
      state     <= stateNxt;
      sel       <= selNxt;
      addr      <= addrNxt;
      wdata     <= wdataNxt;
      sendByte  <= sendNxt;
      pfBuf     <= pfNxt;
      errOvr    <= ovrNxt;
      closePend <= closeNxt;
      cmdSeen   <= cmdSeenNxt;
    end
  end

  assign oSPI_SEND_BYTE = sendByte;
  assign oBUS_SEL       = sel;
  assign oBUS_ADDR      = addr;
  assign oBUS_WDATA     = wdata;
  assign oBUS_WR        = (state == WR_REQ);
  assign oBUS_RD        = (state == RD_REQ);
  assign oBUSY          = (state != IDLE);
  assign oERR_OVR       = errOvr;

endmodule

// File: tb/tb_spi_periph_sequencer.sv
// Directed bench for spi_periph_sequencer: SPI strobes driven directly, bus memory responder.
module tb_spi_periph_sequencer;

  localparam int ADDR_W = 3;
  localparam int SB_W   = 16 + ADDR_W + 8;
  localparam int GAP    = 30;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ss_n = 1'b1;
  logic              wr_sig = 1'b0;
  logic              rd_sig = 1'b0;
  logic [7:0]        rcv_cmd = 8'h00;
  logic [7:0]        rcv_byte = 8'h00;
  logic [7:0]        send_byte;
  logic [15:0]       bus_sel;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_wr, bus_rd;
  logic              bus_ack = 1'b0;
  logic [7:0]        bus_rdata = 8'h00;
  logic              busy, err_ovr, err_tmo;

  int vectors = 0;
  int miscompares = 0;
  int ack_delay = 0;
  bit ack_enable = 1'b1;
  logic [7:0] mem [8];
  logic [SB_W-1:0] exp_q[$];

  spi_periph_sequencer #(.ADDR_W(ADDR_W), .TMO_CYC(4)) dut (
    .iCLK(clk), .iRST(rst), .iSPI_SS_n(ss_n), .iSPI_WRITE_SIG(wr_sig),
    .iSPI_READ_SIG(rd_sig), .iSPI_RCV_CMD(rcv_cmd), .iSPI_RCV_BYTE(rcv_byte),
    .oSPI_SEND_BYTE(send_byte), .oBUS_SEL(bus_sel), .oBUS_ADDR(bus_addr),
    .oBUS_WDATA(bus_wdata), .oBUS_WR(bus_wr), .oBUS_RD(bus_rd), .iBUS_ACK(bus_ack),
    .iBUS_RDATA(bus_rdata), .oBUSY(busy), .oERR_OVR(err_ovr), .oERR_TMO(err_tmo));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // bus responder / write scoreboard
  task automatic score_write();
    logic [SB_W-1:0] got;
    got = {bus_sel, bus_addr, bus_wdata};
    if (exp_q.size() > 0) check("wr_sb", 32'(got), 32'(exp_q.pop_front()));
    else                  check("wr_unexpected", 32'(got), 32'hFFFF_FFFF);
  endtask

  initial begin
    int wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if ((bus_wr || bus_rd) && !bus_ack) begin
        if (ack_enable && wait_cnt >= ack_delay) begin
          bus_ack = 1'b1;
          if (bus_rd) bus_rdata = mem[bus_addr];
          if (bus_wr) score_write();
        end else begin
          wait_cnt++;
        end
      end else begin
        bus_ack = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  // driver tasks
  task automatic ss_begin();
    @(negedge clk); ss_n = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic ss_end();
    @(negedge clk); ss_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic read_pulse();
    @(negedge clk); rd_sig = 1'b1;
    repeat (4) @(negedge clk);
    rd_sig = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic write_pulse(input logic [7:0] data);
    @(negedge clk); rcv_byte = data; wr_sig = 1'b1;
    repeat (4) @(negedge clk);
    wr_sig = 1'b0;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic wait_req(input bit is_rd, input logic level, input int budget, input string tag);
    int n;
    n = 0;
    while ((is_rd ? bus_rd : bus_wr) !== level && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(is_rd ? bus_rd : bus_wr), 32'(level));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_sel"}, 32'(bus_sel), 0);
    check({tag, "_addr"}, 32'(bus_addr), 0);
    check({tag, "_send"}, 32'(send_byte), 0);
    check({tag, "_wr"}, 32'(bus_wr), 0);
    check({tag, "_rd"}, 32'(bus_rd), 0);
  endtask

  // directed sequence
  initial begin
    int n;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset_wdata", 32'(bus_wdata), 0);
    check("reset_ovr", 32'(err_ovr), 0);
    check("reset_tmo", 32'(err_tmo), 0);

    // write 0x11, 0x22 to periph 3 starting at address 2
    rcv_cmd = 8'h9A;
    exp_q.push_back({16'h0008, 3'd2, 8'h11});
    exp_q.push_back({16'h0008, 3'd3, 8'h22});
    ss_begin();
    check("wr_busy", 32'(busy), 1);
    read_pulse();
    read_pulse();
    check("wr_sel", 32'(bus_sel), 32'h0008);
    check("wr_addr0", 32'(bus_addr), 2);
    write_pulse(8'h11);
    read_pulse();
    write_pulse(8'h22);
    check("wr_addr2", 32'(bus_addr), 4);
    ss_end();
    check_quiet("wr_end");

    // read periph 5 from address 0, four data bytes
    rcv_cmd = 8'h28;
    ss_begin();
    read_pulse();
    read_pulse();
    check("rd_sel", 32'(bus_sel), 32'h0020);
    check("rd_byte1", 32'(send_byte), 32'h00);
    read_pulse();
    check("rd_byte2", 32'(send_byte), 32'hA0);
    read_pulse();
    check("rd_byte3", 32'(send_byte), 32'hA1);
    read_pulse();
    check("rd_byte4", 32'(send_byte), 32'hA2);
    check("rd_ovr", 32'(err_ovr), 0);
    ss_end();
    check_quiet("rd_end");

    // address wrap: periph 0, start at 7
    rcv_cmd = 8'h87;
    exp_q.push_back({16'h0001, 3'd7, 8'h5A});
    exp_q.push_back({16'h0001, 3'd0, 8'h5B});
    ss_begin();
    read_pulse();
    read_pulse();
    check("wrap_addr0", 32'(bus_addr), 7);
    write_pulse(8'h5A);
    check("wrap_addr1", 32'(bus_addr), 0);
    write_pulse(8'h5B);
    check("wrap_addr2", 32'(bus_addr), 1);
    ss_end();

    // SS rise while a write request waits on a 5-cycle ack
    rcv_cmd = 8'h9A;
    exp_q.push_back({16'h0008, 3'd2, 8'h33});
    ss_begin();
    read_pulse();
    read_pulse();
    ack_delay = 5;
    @(negedge clk); rcv_byte = 8'h33; wr_sig = 1'b1;
    wait_req(1'b0, 1'b1, 20, "ssr_wr_up");
    ss_n = 1'b1; wr_sig = 1'b0;
    repeat (4) @(negedge clk);
    check("ssr_wr_held", 32'(bus_wr), 1);
    wait_req(1'b0, 1'b0, 20, "ssr_wr_down");
    repeat (2) @(negedge clk);
    check_quiet("ssr_end");
    check("ssr_wdata", 32'(bus_wdata), 0);
    check("ssr_ovr", 32'(err_ovr), 0);
    ack_delay = 0;
    repeat (10) @(negedge clk);

    // overrun: second write strobe while the first write is stalled
    rcv_cmd = 8'h9A;
    exp_q.push_back({16'h0008, 3'd2, 8'h44});
    ack_delay = 100;
    ss_begin();
    read_pulse();
    read_pulse();
    write_pulse(8'h44);
    check("ovr_wr_held", 32'(bus_wr), 1);
    check("ovr_before", 32'(err_ovr), 0);
    write_pulse(8'h55);
    check("ovr_flag", 32'(err_ovr), 1);
    check("ovr_wdata", 32'(bus_wdata), 32'h44);
    wait_req(1'b0, 1'b0, 200, "ovr_wr_down");
    ss_end();
    check("ovr_sticky", 32'(err_ovr), 1);
    ack_delay = 0;

`ifdef SPI_SEQ_TIMEOUT_EN
    // read with no ack: request drops after 4 cycles, next byte is 0xFF
    ack_enable = 1'b0;
    rcv_cmd = 8'h28;
    ss_begin();
    read_pulse();
    @(negedge clk); rd_sig = 1'b1;
    wait_req(1'b1, 1'b1, 20, "tmo_rd_up");
    n = 0;
    while (bus_rd === 1'b1 && n < 50) begin
      n++;
      @(negedge clk);
    end
    rd_sig = 1'b0;
    check("tmo_rd_cycles", 32'(n), 4);
    check("tmo_flag", 32'(err_tmo), 1);
    repeat (GAP) @(negedge clk);
    read_pulse();
    check("tmo_byte", 32'(send_byte), 32'hFF);
    ss_end();
    ack_enable = 1'b1;
`else
    n = 0;
    check("tmo_tied", 32'(err_tmo), 32'(n));
`endif

    check("sb_pending", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_periph_sequencer.md
# spi_periph_sequencer

System-clock-side controller for the SPI slave front end. It synchronises the slave's SS, read/write strobes, command and received byte into `iCLK`. It decodes the peripheral select and sequences one-word accesses on a shared req/ack peripheral bus with an auto-incrementing address. It keeps `oSPI_SEND_BYTE` loaded with prefetched read data one SPI byte ahead. It sits between the SPI slave and the register/peripheral fabric, and is the sole master of that bus.

## Interface
Parameters:
- `ADDR_W`, 8: peripheral bus address width.
- `TMO_CYC`, 255: ack timeout in `iCLK` cycles (used only with `SPI_SEQ_TIMEOUT_EN`).

Ports:
- `iCLK`  in  1  system clock; the block has one clock.
- `iRST`  in  1  reset, synchronous and active-high.
- `iSPI_SS_n`  in  1  slave select from the SPI slave (async).
- `iSPI_WRITE_SIG`  in  1  write strobe (async).
- `iSPI_READ_SIG`  in  1  byte-start strobe (async).
- `iSPI_RCV_CMD`  in  8  latched command: [7] = write, [6:3] = peripheral, [2:0] = start address.
- `iSPI_RCV_BYTE`  in  8  received data byte.
- `oSPI_SEND_BYTE`  out  8  byte shifted out by the slave.
- `oBUS_SEL`  out  16  one-hot peripheral select.
- `oBUS_ADDR`  out  ADDR_W  word address.
- `oBUS_WDATA`  out  8  write data.
- `oBUS_WR`  out  1  write request, held until ack.
- `oBUS_RD`  out  1  read request, held until ack.
- `iBUS_ACK`  in  1  access complete.
- `iBUS_RDATA`  in  8  read data, valid with ack.
- `oBUSY`  out  1  SPI transaction open (state is not IDLE).
- `oERR_OVR`  out  1  sticky write overrun.
- `oERR_TMO`  out  1  sticky ack timeout.

## Operation
- SS, write strobe and read strobe each pass through a 2-FF synchronizer followed by an edge register. Events used: SS fall, SS rise, write-strobe rise, read-strobe rise.
- Command and byte are sampled on the cycle an event is detected.
- States:
  - IDLE: wait for SS fall.
  - CMD: wait for the 2nd read-strobe rise (end of the command byte). On it, latch `oBUS_SEL` = onehot(cmd[6:3]) and `oBUS_ADDR` = cmd[2:0] zero-extended. If cmd[7]=1, go to WR_IDLE. If cmd[7]=0, go to RD_REQ.
  - WR_IDLE: on a write-strobe rise, capture the byte into `oBUS_WDATA` and go to WR_REQ.
  - WR_REQ: hold `oBUS_WR`. On ack, increment the address and return to WR_IDLE.
  - RD_REQ: hold `oBUS_RD`. On ack, store `iBUS_RDATA` in the prefetch buffer, increment the address and go to RD_WAIT.
  - RD_WAIT: on a read-strobe rise, copy the buffer to `oSPI_SEND_BYTE` and go to RD_REQ.
- `oSPI_SEND_BYTE` changes only on a read-strobe rise, so a byte is never modified mid-shift. Data byte 1 of a read returns 0x00. Byte n≥2 returns mem[start+n-2].
- A read-strobe rise arriving while in RD_REQ: load 0x00 and set `oERR_OVR`.
- Write pending depth is 1. A write-strobe rise seen while in WR_REQ sets `oERR_OVR`, and that byte is dropped.
- Address wraps modulo 2^ADDR_W.
- SS rise in any state: an outstanding WR/RD request completes its handshake first (requests are never withdrawn). Then go to IDLE, and `oBUS_SEL` and `oSPI_SEND_BYTE` return to 0.
- Error flags clear only on `iRST`.

## Timing
- Reset values: every output 0; state IDLE; prefetch buffer 0.
- Async input to detected event: 3 `iCLK` cycles.
- `oBUS_WR` asserts 1 cycle after the write-strobe event.
- Request deasserts the cycle after ack is sampled high. Ack coincident with request assertion is legal; minimum access is 1 cycle.
- SPI clock period must be at least 16 `iCLK` cycles. This guarantees sync latency plus a 1-cycle access completes within one bit time.

## Configuration
- `SPI_SEQ_TIMEOUT_EN` defined: a counter runs while a request is held. At TMO_CYC cycles without ack, drop the request, set `oERR_TMO` and proceed as if acked. The read substitutes 0xFF; the write is discarded.
- Without `SPI_SEQ_TIMEOUT_EN`: the block waits for ack indefinitely, and `oERR_TMO` is tied 0.

## Structure
- Package `spi_seq_pkg`: state enum, `SEL_W`=16, `DUMMY_BYTE`=8'h00, `TMO_BYTE`=8'hFF.
- Sub-module `spi_sync_edge`: 2-FF synchronizer plus rise/fall detect. Instantiated 3×.

## Test plan
- Write, cmd 0x9A (write, periph 3, addr 2), data 0x11, 0x22, 1-cycle ack: `oBUS_SEL`=0x0008; writes 0x11@2 and 0x22@3.
- Read, cmd 0x28 (periph 5, addr 0), mem = {0xA0, 0xA1, 0xA2}, 4 data bytes: MISO returns 0x00, 0xA0, 0xA1, 0xA2.
- Address wrap, ADDR_W=3, write from addr 7 with 2 bytes: accesses at addresses 7 then 0.
- SS rise while `oBUS_WR` is held and ack delayed 5 cycles: request stays high until ack, then IDLE with all outputs 0.
- Two write-strobe rises while ack is stalled: `oERR_OVR`=1; only the first byte is written.
- With `SPI_SEQ_TIMEOUT_EN` and TMO_CYC=4, read with ack never returned: `oBUS_RD` drops after 4 cycles, `oERR_TMO`=1, next data byte = 0xFF.
